// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI slave front end for a small command-driven RAM. A frame carries a 10-bit
// command word, MSB first: [9:8] opcode, [7:0] address or data. The assembled
// word is handed to the RAM with a one-cycle rx_valid strobe. On a read-data
// command the RAM's answer (tx_data/tx_valid) is serialised back on MISO.
//
// Ports
//   clk       in   system/SPI clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   SS_n      in   active-low slave select, low while a frame is in progress
//   MOSI      in   serial command bits from the master, MSB first
//   MISO      out  serial read data to the master, MSB first, 0 when idle
//   rx_data   out  assembled command word to the RAM
//   rx_valid  out  one-cycle strobe qualifying rx_data
//   tx_data   in   read data returned by the RAM
//   tx_valid  in   RAM read-data valid (level, may linger across cycles)
// -----------------------------------------------------------------------------
module spi_slave (
   input  logic       clk,
   input  logic       rst,
   input  logic       SS_n,
   input  logic       MOSI,
   output logic       MISO,
   output logic [9:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   state_t     state_r;
   logic [3:0] bit_cnt_r;       // shifted command bits after the opcode MSB
   logic       rd_addr_flag_r;  // a read address has been latched, next read is data
   logic       wait_r;          // armed after a read-data command, waits for tx_valid
   logic [7:0] tx_shift_r;      // remaining read bits, next one in [7]
   logic [2:0] tx_cnt_r;        // read bits still to present after the current one
   logic [9:0] rx_data_r;
   logic       rx_valid_r;
   logic       miso_r;

   assign MISO     = miso_r;
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;

   // Frame FSM, command deserialiser and read-data serialiser
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         bit_cnt_r      <= 4'd0;
         rd_addr_flag_r <= 1'b0;
         wait_r         <= 1'b0;
         tx_shift_r     <= 8'h00;
         tx_cnt_r       <= 3'd0;
         rx_data_r      <= 10'h000;
         rx_valid_r     <= 1'b0;
         miso_r         <= 1'b0;
      end else if ((state_r != IDLE) && SS_n) begin
         // Master released select: abandon the frame; the read-address
         // flag survives so an address phase is not lost.
         state_r    <= IDLE;
         bit_cnt_r  <= 4'd0;
         wait_r     <= 1'b0;
         tx_shift_r <= 8'h00;
         tx_cnt_r   <= 3'd0;
         rx_valid_r <= 1'b0;
         miso_r     <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               bit_cnt_r <= 4'd0;
               if (!SS_n) begin
                  state_r <= CHK_CMD;
               end else begin
                  state_r <= IDLE;
               end
            end
            CHK_CMD: begin
               rx_data_r[9] <= MOSI;
               bit_cnt_r    <= 4'd0;
               if (!MOSI) begin
                  state_r <= WRITE;
               end else if (rd_addr_flag_r) begin
                  state_r <= READ_DATA;
               end else begin
                  state_r <= READ_ADD;
               end
            end
            WRITE, READ_ADD, READ_DATA: begin
               // Nine more bits complete the word; anything after is ignored
               // until the master deselects.
               if (bit_cnt_r < 4'd9) begin
                  rx_data_r[8:0] <= {rx_data_r[7:0], MOSI};
                  bit_cnt_r      <= bit_cnt_r + 4'd1;
                  if (bit_cnt_r == 4'd8) begin
                     rx_valid_r <= 1'b1;
                     if (state_r == READ_ADD) begin
                        rd_addr_flag_r <= 1'b1;
                     end else if (state_r == READ_DATA) begin
                        rd_addr_flag_r <= 1'b0;
                     end
                  end
               end
               // Arm only once the read command has been strobed, so a
               // tx_valid level left over from an earlier read is never taken.
               if ((state_r == READ_DATA) && rx_valid_r) begin
                  wait_r <= 1'b1;
               end else if (wait_r && tx_valid) begin
                  wait_r     <= 1'b0;
                  miso_r     <= tx_data[7];
                  tx_shift_r <= {tx_data[6:0], 1'b0};
                  tx_cnt_r   <= 3'd7;
               end else if (tx_cnt_r != 3'd0) begin
                  miso_r     <= tx_shift_r[7];
                  tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                  tx_cnt_r   <= tx_cnt_r - 3'd1;
               end else begin
                  miso_r <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system/SPI clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 SS_n  input  1  active-low slave select; low = frame in progress.
REQ-005 MOSI  input  1  serial data from master, sampled on clk rising edge, MSB first.
REQ-006 MISO  output  1  serial read data to master, MSB first.
REQ-007 rx_data  output  10  assembled command word to the RAM: [9:8] opcode, [7:0] address/data.
REQ-008 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  input  8  read data returned by the RAM.
REQ-010 tx_valid  input  1  RAM read-data valid; level, may stay high across later cycles.

Function
REQ-011 FSM states SHALL be: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE: SS_n=1 -> stay; SS_n=0 -> CHK_CMD next edge.
REQ-013 CHK_CMD: the MOSI bit sampled here SHALL become rx_data[9]; 0 -> WRITE; 1 and rd_addr_flag=0 -> READ_ADD; 1 and rd_addr_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA: the next 9 edges SHALL shift MOSI into rx_data[8:0], MSB first, via a 4-bit bit counter.
REQ-015 On the 9th shifted bit, rx_data SHALL be complete and rx_valid SHALL be high for exactly the following cycle; extra bits afterwards are ignored.
REQ-016 Timing: the first SS_n=0 edge in IDLE is edge k; bit9 is sampled at k+1, bits 8..0 at k+2..k+10, and rx_valid is high between edges k+10 and k+11.
REQ-017 rd_addr_flag SHALL set when rx_valid is issued from READ_ADD and clear when rx_valid is issued from READ_DATA; it is unaffected by WRITE frames.
REQ-018 READ_DATA, after rx_valid: the block SHALL arm a wait flag, then load tx_data into an 8-bit shift register on the first edge where tx_valid=1 and the wait flag is set, then clear the wait flag.
REQ-019 Any tx_valid high outside an armed wait SHALL be ignored, including a stale level held over from a previous read.
REQ-020 After the load, MISO SHALL present tx_data[7] until the next edge, then bits 6..0 on successive edges; after 8 bits, MISO returns to 0.
REQ-021 With a 1-cycle RAM latency, tx_valid is seen at edge k+12 and MISO carries bits 7..0 during cycles k+12..k+19.
REQ-022 SS_n=1 in any non-IDLE state SHALL force IDLE at the next edge: the frame aborts, the counter clears, no rx_valid is issued, MISO=0, and the wait flag is cleared; rd_addr_flag keeps its value.
REQ-023 A frame that ends in any state other than IDLE SHALL only restart after passing through IDLE, i.e. SS_n must go high at least one edge.
REQ-024 A new frame beginning while MISO is still shifting is impossible by REQ-023; an SS_n rise mid-shift truncates the output per REQ-022.

Reset
REQ-025 On an edge with rst=1 the block SHALL set: state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_flag=0, wait flag=0, and MISO shift register=0.
REQ-026 rst asserted mid-frame SHALL override all other activity; no rx_valid is issued on or after the reset edge.

Verification
REQ-027 Write address: SS_n low, MOSI=0,0,0xA5 bits -> rx_data=10'h0A5 and rx_valid for 1 cycle at k+10; MISO stays 0.
REQ-028 Write data then read back: send 10'h0A5 then 10'h15A (write 0x5A), then 10'h2A5 -> rd_addr_flag=1; then send 10'h3xx -> with the RAM attached, MISO serializes 0x5A MSB first at k+12..k+19 and rd_addr_flag=0.
REQ-029 Stale tx_valid: hold tx_valid=1 and tx_data=0xFF before a READ_DATA frame -> nothing loads until after the frame's rx_valid; MISO stays 0 until then.
REQ-030 Abort: SS_n high after 5 bits of a write frame -> IDLE next edge, no rx_valid, counter=0; the next full frame decodes correctly.
REQ-031 Reset mid-read while MISO is shifting -> MISO=0, state=IDLE, rd_addr_flag=0 on the next edge.
REQ-032 Back-to-back frames separated by a single SS_n-high cycle -> both decode, with both rx_valid pulses 12 cycles apart.
